decode_stage: RTL and testbench

Registered, handshaked RV32 instruction-decode pipeline stage. Accepts fetched instructions with their PC, splits them into register and function fields, generates the sign-extended immediate, and classifies the format. Optionally accepts the M extension and flags illegal encodings. Sits between fetch and register-read/execute, and absorbs downstream stalls with a skid register so that `in_ready` never depends combinationally on `out_ready`.

---
 rtl/decode_pkg.sv | 47 ++++
 rtl/decode_stage_if.sv | 35 +++
 rtl/decode_comb.sv | 128 ++++++++++++
 rtl/decode_stage.sv | 79 +++++++
 tb/tb_decode_stage.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/decode_pkg.sv
// Shared definitions for the RV32 decode stage: base opcodes, the format
// classification enum and the decoded bundle that travels down the pipe.
package decode_pkg;

  // RV32I base opcodes (instr[6:0])
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Widest PC the bundle can carry; narrower PCs are zero-extended into it.
  localparam int PC_MAX_WIDTH = 32;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [PC_MAX_WIDTH-1:0] pc;
    logic [6:0]              opcode;
    logic [4:0]              rd;
    logic [4:0]              rs1;
    logic [4:0]              rs2;
    logic [2:0]              funct3;
    logic [6:0]              funct7;
    logic [31:0]             imm;
    fmt_e                    fmt;
    logic                    illegal;
  } decoded_t;

  // Sign-extend a 12-bit immediate field to 32 bits.
  function automatic logic [31:0] sext12(input logic [11:0] value);
    return {{20{value[11]}}, value};
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Handshake bundle between fetch, the decode stage and its consumer.
// master is the environment side (fetch + consumer), slave is the stage.
interface decode_stage_if #(
  parameter int PC_WIDTH = 32
);
  logic                flush;
  logic                in_valid;
  logic                in_ready;
  logic [31:0]         in_instr;
  logic [PC_WIDTH-1:0] in_pc;
  logic                out_valid;
  logic                out_ready;
  logic [PC_WIDTH-1:0] out_pc;
  logic [6:0]          out_opcode;
  logic [4:0]          out_rd;
  logic [4:0]          out_rs1;
  logic [4:0]          out_rs2;
  logic [2:0]          out_funct3;
  logic [6:0]          out_funct7;
  logic [31:0]         out_imm;
  logic [2:0]          out_fmt;
  logic                out_illegal;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_fmt, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_opcode, out_rd, out_rs1, out_rs2,
           out_funct3, out_funct7, out_imm, out_fmt, out_illegal
  );
endinterface

// File: rtl/decode_comb.sv
// Purely combinational RV32I(+M) field splitter, immediate generator and
// legality checker. Illegal encodings collapse to a zeroed FMT_NONE bundle
// that still carries opcode and PC.
module decode_comb
  import decode_pkg::*;
#(
  parameter int PC_WIDTH = 32,
  parameter bit ENABLE_M = 1'b0
) (
  input  logic [31:0]         instr,
  input  logic [PC_WIDTH-1:0] pc,
  output decoded_t            dec
);

  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic        bad;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = sext12(instr[31:20]);
  assign imm_s = sext12({instr[31:25], instr[11:7]});
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Gate fields per opcode, pick the immediate and flag unsupported encodings.
  always_comb begin
    dec        = '0;
    dec.pc     = PC_MAX_WIDTH'(pc);
    dec.opcode = opcode;
    dec.fmt    = FMT_NONE;
    bad        = 1'b0;
    case (opcode)
      OP_R: begin
        dec.fmt    = FMT_R;
        dec.rd     = rd;
        dec.rs1    = rs1;
        dec.rs2    = rs2;
        dec.funct3 = funct3;
        dec.funct7 = funct7;
        bad = !((funct7 == 7'b0000000) ||
                (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) ||
                (ENABLE_M && funct7 == 7'b0000001));
      end
      OP_IMM: begin
        dec.fmt    = FMT_I;
        dec.rd     = rd;
        dec.rs1    = rs1;
        dec.rs2    = rs2;
        dec.funct3 = funct3;
        dec.funct7 = funct7;
        dec.imm    = imm_i;
        if (funct3 == 3'b001)
          bad = (funct7 != 7'b0000000);
        else if (funct3 == 3'b101)
          bad = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
      end
      OP_LOAD: begin
        dec.fmt    = FMT_I;
        dec.rd     = rd;
        dec.rs1    = rs1;
        dec.funct3 = funct3;
        dec.imm    = imm_i;
        bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OP_JALR: begin
        dec.fmt    = FMT_I;
        dec.rd     = rd;
        dec.rs1    = rs1;
        dec.funct3 = funct3;
        dec.imm    = imm_i;
        bad = (funct3 != 3'b000);
      end
      OP_STORE: begin
        dec.fmt    = FMT_S;
        dec.rs1    = rs1;
        dec.rs2    = rs2;
        dec.funct3 = funct3;
        dec.imm    = imm_s;
        bad = (funct3 > 3'b010);
      end
      OP_BRANCH: begin
        dec.fmt    = FMT_B;
        dec.rs1    = rs1;
        dec.rs2    = rs2;
        dec.funct3 = funct3;
        dec.imm    = imm_b;
        bad = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OP_LUI, OP_AUIPC: begin
        dec.fmt = FMT_U;
        dec.rd  = rd;
        dec.imm = imm_u;
      end
      OP_JAL: begin
        dec.fmt = FMT_J;
        dec.rd  = rd;
        dec.imm = imm_j;
      end
      default: bad = 1'b1;
    endcase
    if (instr[1:0] != 2'b11)
      bad = 1'b1;
    if (bad) begin
      dec         = '0;
      dec.pc      = PC_MAX_WIDTH'(pc);
      dec.opcode  = opcode;
      dec.fmt     = FMT_NONE;
      dec.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered, handshaked RV32 decode stage. A main output register plus a
// skid register let in_ready come purely from state (!skid_valid), so the
// upstream never sees a combinational path from out_ready.
module decode_stage
  import decode_pkg::*;
#(
  parameter int PC_WIDTH = 32,
  parameter bit ENABLE_M = 1'b0
) (
  input logic            clk,
  input logic            rst_n,
  decode_stage_if.slave  bus
);

  decoded_t dec;
  decoded_t main_q;
  decoded_t skid_q;
  logic     main_valid;
  logic     skid_valid;
  logic     take_in;
  logic     take_out;

  decode_comb #(
    .PC_WIDTH (PC_WIDTH),
    .ENABLE_M (ENABLE_M)
  ) u_decode_comb (
    .instr (bus.in_instr),
    .pc    (bus.in_pc),
    .dec   (dec)
  );

  // A flush drops whatever is offered this cycle, so it never counts as taken.
  assign take_in  = bus.in_valid && !skid_valid && !bus.flush;
  assign take_out = main_valid && bus.out_ready;

  // Main/skid storage: keeps FIFO order, refills main from skid on consume.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (bus.flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else if (take_out) begin
      if (skid_valid) begin
        main_q     <= skid_q;
        skid_valid <= 1'b0;
      end else if (take_in) begin
        main_q <= dec;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (take_in) begin
      if (!main_valid) begin
        main_q     <= dec;
        main_valid <= 1'b1;
      end else begin
        skid_q     <= dec;
        skid_valid <= 1'b1;
      end
    end
  end

  assign bus.in_ready    = !skid_valid;
  assign bus.out_valid   = main_valid;
  assign bus.out_pc      = main_q.pc[PC_WIDTH-1:0];
  assign bus.out_opcode  = main_q.opcode;
  assign bus.out_rd      = main_q.rd;
  assign bus.out_rs1     = main_q.rs1;
  assign bus.out_rs2     = main_q.rs2;
  assign bus.out_funct3  = main_q.funct3;
  assign bus.out_funct7  = main_q.funct7;
  assign bus.out_imm     = main_q.imm;
  assign bus.out_fmt     = main_q.fmt;
  assign bus.out_illegal = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage. Two instances share one stimulus stream:
// dut0 without the M extension, dut1 with it.
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  int          checks = 0;
  int          errors = 0;

  decode_stage_if #(.PC_WIDTH(32)) bus0 ();
  decode_stage_if #(.PC_WIDTH(32)) bus1 ();

  assign bus0.flush     = flush;
  assign bus0.in_valid  = in_valid;
  assign bus0.in_instr  = in_instr;
  assign bus0.in_pc     = in_pc;
  assign bus0.out_ready = out_ready;
  assign bus1.flush     = flush;
  assign bus1.in_valid  = in_valid;
  assign bus1.in_instr  = in_instr;
  assign bus1.in_pc     = in_pc;
  assign bus1.out_ready = out_ready;

  decode_stage #(.PC_WIDTH(32), .ENABLE_M(1'b0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  decode_stage #(.PC_WIDTH(32), .ENABLE_M(1'b1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic valid, input logic [31:0] instr,
                                input logic [31:0] pc);
    in_valid = valid;
    in_instr = instr;
    in_pc    = pc;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Full bundle comparison on the M-less instance.
  task automatic check_bundle(input string tag, input logic [31:0] instr,
                              input logic [31:0] pc, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] imm, input fmt_e fmt,
                              input logic illegal);
    check_output({tag, ".valid"},   32'(bus0.out_valid),   32'd1);
    check_output({tag, ".pc"},      bus0.out_pc,           pc);
    check_output({tag, ".opcode"},  32'(bus0.out_opcode),  32'(instr[6:0]));
    check_output({tag, ".rd"},      32'(bus0.out_rd),      32'(rd));
    check_output({tag, ".rs1"},     32'(bus0.out_rs1),     32'(rs1));
    check_output({tag, ".rs2"},     32'(bus0.out_rs2),     32'(rs2));
    check_output({tag, ".funct3"},  32'(bus0.out_funct3),  32'(f3));
    check_output({tag, ".funct7"},  32'(bus0.out_funct7),  32'(f7));
    check_output({tag, ".imm"},     bus0.out_imm,          imm);
    check_output({tag, ".fmt"},     32'(bus0.out_fmt),     32'(fmt));
    check_output({tag, ".illegal"}, 32'(bus0.out_illegal), 32'(illegal));
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    apply_stimulus(1'b0, 32'h0, 32'h0);
    #12;
    $display("[TB] reset state");
    check_output("rst.out_valid", 32'(bus0.out_valid), 32'd0);
    check_output("rst.in_ready",  32'(bus0.in_ready),  32'd1);
    check_output("rst.out_imm",   bus0.out_imm,        32'd0);
    rst_n = 1'b1;

    $display("[TB] streaming decode with out_ready high");
    out_ready = 1'b1;
    apply_stimulus(1'b1, 32'hFFF10093, 32'h100);          // ADDI x1,x2,-1
    step();
    check_bundle("addi", 32'hFFF10093, 32'h100, 5'd1, 5'd2, 5'd31, 3'd0, 7'h7F,
                 32'hFFFFFFFF, FMT_I, 1'b0);
    apply_stimulus(1'b1, 32'hFE000EE3, 32'h104);          // BEQ x0,x0,-4
    step();
    check_bundle("beq", 32'hFE000EE3, 32'h104, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00,
                 32'hFFFFFFFC, FMT_B, 1'b0);
    apply_stimulus(1'b1, 32'h022081B3, 32'h108);          // MUL x3,x1,x2
    step();
    check_bundle("mul_nom", 32'h022081B3, 32'h108, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00,
                 32'h0, FMT_NONE, 1'b1);
    check_output("mul_m.illegal", 32'(bus1.out_illegal), 32'd0);
    check_output("mul_m.fmt",     32'(bus1.out_fmt),     32'(FMT_R));
    check_output("mul_m.rd",      32'(bus1.out_rd),      32'd3);
    check_output("mul_m.rs1",     32'(bus1.out_rs1),     32'd1);
    check_output("mul_m.rs2",     32'(bus1.out_rs2),     32'd2);
    check_output("mul_m.funct7",  32'(bus1.out_funct7),  32'h01);
    apply_stimulus(1'b1, 32'h123452B7, 32'h10C);          // LUI x5,0x12345
    step();
    check_bundle("lui", 32'h123452B7, 32'h10C, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00,
                 32'h12345000, FMT_U, 1'b0);
    apply_stimulus(1'b1, 32'hFF9FF0EF, 32'h110);          // JAL x1,-8
    step();
    check_bundle("jal", 32'hFF9FF0EF, 32'h110, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00,
                 32'hFFFFFFF8, FMT_J, 1'b0);
    apply_stimulus(1'b1, 32'h0020A423, 32'h114);          // SW x2,8(x1)
    step();
    check_bundle("sw", 32'h0020A423, 32'h114, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00,
                 32'h8, FMT_S, 1'b0);
    apply_stimulus(1'b1, 32'h4030D093, 32'h118);          // SRAI x1,x1,3
    step();
    check_bundle("srai", 32'h4030D093, 32'h118, 5'd1, 5'd1, 5'd3, 3'd5, 7'h20,
                 32'h403, FMT_I, 1'b0);
    apply_stimulus(1'b1, 32'h4230D093, 32'h11C);          // SRAI with funct7 0100001
    step();
    check_bundle("srai_bad", 32'h4230D093, 32'h11C, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00,
                 32'h0, FMT_NONE, 1'b1);
    apply_stimulus(1'b1, 32'h40001033, 32'h120);          // SLL with funct7 0100000
    step();
    check_bundle("sll_bad", 32'h40001033, 32'h120, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00,
                 32'h0, FMT_NONE, 1'b1);
    apply_stimulus(1'b1, 32'h0000B083, 32'h124);          // LOAD funct3 011
    step();
    check_bundle("ld_bad", 32'h0000B083, 32'h124, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00,
                 32'h0, FMT_NONE, 1'b1);
    apply_stimulus(1'b1, 32'h00000001, 32'h128);          // low bits != 11
    step();
    check_bundle("rvc_bad", 32'h00000001, 32'h128, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00,
                 32'h0, FMT_NONE, 1'b1);
    apply_stimulus(1'b0, 32'h0, 32'h0);
    step();
    check_output("drain.out_valid", 32'(bus0.out_valid), 32'd0);

    $display("[TB] stall with skid: A, B, C");
    out_ready = 1'b0;
    apply_stimulus(1'b1, 32'hFFF10093, 32'h200);          // A: ADDI x1
    step();
    check_output("stall1.pc",       bus0.out_pc,         32'h200);
    check_output("stall1.in_ready", 32'(bus0.in_ready),  32'd1);
    apply_stimulus(1'b1, 32'h123452B7, 32'h204);          // B: LUI x5
    step();
    check_output("stall2.pc",       bus0.out_pc,         32'h200);
    check_output("stall2.in_ready", 32'(bus0.in_ready),  32'd0);
    apply_stimulus(1'b1, 32'hFF9FF0EF, 32'h208);          // C: JAL x1
    step();
    check_output("stall3.valid",    32'(bus0.out_valid), 32'd1);
    check_output("stall3.pc",       bus0.out_pc,         32'h200);
    check_output("stall3.imm",      bus0.out_imm,        32'hFFFFFFFF);
    check_output("stall3.in_ready", 32'(bus0.in_ready),  32'd0);
    out_ready = 1'b1;
    step();
    check_output("rel_b.pc",        bus0.out_pc,         32'h204);
    check_output("rel_b.rd",        32'(bus0.out_rd),    32'd5);
    check_output("rel_b.in_ready",  32'(bus0.in_ready),  32'd1);
    step();
    check_output("rel_c.valid",     32'(bus0.out_valid), 32'd1);
    check_output("rel_c.pc",        bus0.out_pc,         32'h208);
    check_output("rel_c.imm",       bus0.out_imm,        32'hFFFFFFF8);
    apply_stimulus(1'b0, 32'h0, 32'h0);
    step();
    check_output("rel_end.valid",   32'(bus0.out_valid), 32'd0);

    $display("[TB] flush with skid full");
    out_ready = 1'b0;
    apply_stimulus(1'b1, 32'hFFF10093, 32'h300);
    step();
    apply_stimulus(1'b1, 32'hFE000EE3, 32'h304);
    step();
    check_output("fl_full.in_ready", 32'(bus0.in_ready), 32'd0);
    apply_stimulus(1'b1, 32'h0020A423, 32'h308);
    flush = 1'b1;
    step();
    check_output("fl.out_valid", 32'(bus0.out_valid), 32'd0);
    check_output("fl.in_ready",  32'(bus0.in_ready),  32'd1);
    flush     = 1'b0;
    out_ready = 1'b1;
    apply_stimulus(1'b0, 32'h0, 32'h0);
    step();
    check_output("fl_gone.out_valid", 32'(bus0.out_valid), 32'd0);
    apply_stimulus(1'b1, 32'h123452B7, 32'h30C);
    step();
    check_output("fl_next.valid", 32'(bus0.out_valid), 32'd1);
    check_output("fl_next.pc",    bus0.out_pc,         32'h30C);
    apply_stimulus(1'b0, 32'h0, 32'h0);
    step();

    $display("[TB] async reset mid-stall");
    out_ready = 1'b0;
    apply_stimulus(1'b1, 32'hFFF10093, 32'h400);
    step();
    apply_stimulus(1'b1, 32'hFF9FF0EF, 32'h404);
    step();
    apply_stimulus(1'b0, 32'h0, 32'h0);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("arst.out_valid", 32'(bus0.out_valid), 32'd0);
    check_output("arst.in_ready",  32'(bus0.in_ready),  32'd1);
    check_output("arst.pc",        bus0.out_pc,         32'h0);
    check_output("arst.opcode",    32'(bus0.out_opcode), 32'd0);
    check_output("arst.rd",        32'(bus0.out_rd),    32'd0);
    check_output("arst.imm",       bus0.out_imm,        32'h0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    apply_stimulus(1'b1, 32'h0020A423, 32'h500);
    step();
    check_output("post_rst.valid", 32'(bus0.out_valid), 32'd1);
    check_output("post_rst.pc",    bus0.out_pc,         32'h500);
    check_output("post_rst.imm",   bus0.out_imm,        32'h8);
    apply_stimulus(1'b0, 32'h0, 32'h0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
